stopwatch_ctrl: RTL and testbench

Upstream control and timekeeping stage for the four-digit seven-segment stopwatch display. It debounces the raw start/stop and clear push-buttons and runs a run/pause/idle state machine. It also generates the count tick and maintains four cascaded BCD decade digits. `count1`..`count4` connect directly to the display multiplexer's digit inputs, with `count1` as the least-significant digit. The mux, scan counter and 7-segment decoder downstream are unchanged.

---
 rtl/stopwatch_ctrl_if.sv | 25 ++
 rtl/stopwatch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display-side outputs of the stopwatch control stage.
interface stopwatch_ctrl_if;
  localparam int unsigned DIGIT_W = 4;

  logic               btn_start;
  logic               btn_clear;
  logic [DIGIT_W-1:0] count1;
  logic [DIGIT_W-1:0] count2;
  logic [DIGIT_W-1:0] count3;
  logic [DIGIT_W-1:0] count4;
  logic               running;
  logic               overflow;

  // Environment side: drives the raw buttons, observes digits and status.
  modport master (
    output btn_start, btn_clear,
    input  count1, count2, count3, count4, running, overflow
  );

  // Stopwatch side: samples the raw buttons, drives digits and status.
  modport slave (
    input  btn_start, btn_clear,
    output count1, count2, count3, count4, running, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronise/debounce, run/pause/idle FSM,
// count prescaler and four cascaded BCD digits for the display mux.

// One button: 2-flop synchroniser, stability-counter debouncer, rising press pulse.
module stopwatch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            meta;
  logic            sync;
  logic            level;
  logic [DB_W-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync;
        cnt   <= '0;
        // Only an accepted rise is a press; an accepted release is silent.
        press <= sync;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 1_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned PS_W       = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  logic                                start_press;
  logic                                clear_press;
  state_t                              state_q;
  state_t                              state_d;
  logic                                running_q;
  logic                                running_d;
  logic [PS_W-1:0]                     presc_q;
  logic [PS_W-1:0]                     presc_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digit_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digit_d;
  logic                                overflow_q;
  logic                                overflow_d;
  logic                                tick_c;
  logic [NUM_DIGITS-1:0]               wrap_c;

  // Next value of one decade digit on an increment; 9 (or any illegal value) wraps to 0.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(9)) ? '0 : d + DIGIT_W'(1);
  endfunction

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (sw.btn_start),
    .press   (start_press)
  );

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (sw.btn_clear),
    .press   (clear_press)
  );

  // A count tick is the last prescaler cycle while running.
  assign tick_c    = (state_q == ST_RUN) && (presc_q == PS_W'(TICK_DIV - 1));
  assign wrap_c[0] = (digit_q[0] >= DIGIT_W'(9));
  assign wrap_c[1] = (digit_q[1] >= DIGIT_W'(9));
  assign wrap_c[2] = (digit_q[2] >= DIGIT_W'(9));
  assign wrap_c[3] = (digit_q[3] >= DIGIT_W'(9));

  // State register; running tracks the state on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
    end
  end

  // Next state: clear overrides start; start toggles between run and pause.
  always_comb begin
    state_d = state_q;
    if (clear_press) begin
      state_d = ST_IDLE;
    end else if (start_press) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // Prescaler and digit cascade next values; clear beats a coincident tick.
  always_comb begin
    presc_d    = presc_q;
    digit_d    = digit_q;
    overflow_d = 1'b0;
    if (clear_press || (state_q == ST_IDLE)) begin
      presc_d = '0;
      digit_d = '0;
    end else if (state_q == ST_RUN) begin
      if (tick_c) begin
        presc_d    = '0;
        digit_d[0] = bcd_inc(digit_q[0]);
        if (wrap_c[0]) begin
          digit_d[1] = bcd_inc(digit_q[1]);
        end
        if (&wrap_c[1:0]) begin
          digit_d[2] = bcd_inc(digit_q[2]);
        end
        if (&wrap_c[2:0]) begin
          digit_d[3] = bcd_inc(digit_q[3]);
        end
        // Every digit wrapping at once is the 9999 -> 0000 rollover.
        overflow_d = &wrap_c;
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      digit_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      overflow_q <= overflow_d;
    end
  end

  assign sw.count1   = digit_q[0];
  assign sw.count2   = digit_q[1];
  assign sw.count3   = digit_q[2];
  assign sw.count4   = digit_q[3];
  assign sw.running  = running_q;
  assign sw.overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=5, DEBOUNCE_CYCLES=4.
// Stimulus pushes cycle-stamped expectations; the monitor compares them when due.
module tb_stopwatch_ctrl;
  localparam int unsigned TICK_DIV = 5;
  localparam int unsigned DB       = 4;

  typedef struct {
    int    cyc;
    string tag;
    int    value;
    bit    run;
    bit    ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ovf_seen = 0;
  exp_t exp_q[$];

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic void expect_at(input int c, input string tag, input int value,
                                    input bit run, input bit ovf);
    exp_t e;
    e.cyc   = c;
    e.tag   = tag;
    e.value = value;
    e.run   = run;
    e.ovf   = ovf;
    exp_q.push_back(e);
  endfunction

  // Wait (at negedges) until the cycle counter reaches n.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Raise the chosen buttons at the negedge of cycle k and release 10 cycles later.
  task automatic press(input bit s, input bit c, input int k);
    wait_cyc(k);
    sw_if.btn_start = s;
    sw_if.btn_clear = c;
    wait_cyc(k + 10);
    sw_if.btn_start = 1'b0;
    sw_if.btn_clear = 1'b0;
  endtask

  // Monitor: just after each edge, compare every expectation due this cycle.
  always begin
    logic [15:0] got;
    @(posedge clk);
    #1;
    if (sw_if.overflow === 1'b1) ovf_seen++;
    got = {sw_if.count4, sw_if.count3, sw_if.count2, sw_if.count1};
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        checks++;
        if (got !== to_bcd(exp_q[i].value) || sw_if.running !== exp_q[i].run ||
            sw_if.overflow !== exp_q[i].ovf) begin
          errors++;
          $display("FAIL %s cyc=%0d: got digits=%h run=%b ovf=%b, want digits=%h run=%b ovf=%b",
                   exp_q[i].tag, cyc, got, sw_if.running, sw_if.overflow,
                   to_bcd(exp_q[i].value), exp_q[i].run, exp_q[i].ovf);
        end
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc=%0d never sampled (now %0d)",
                 exp_q[i].tag, exp_q[i].cyc, cyc);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sw_if.btn_start = 1'b0;
    sw_if.btn_clear = 1'b0;

    // Reset state and first cycle after reset release.
    expect_at(2, "reset_state", 0, 1'b0, 1'b0);
    expect_at(3, "reset_release", 0, 1'b0, 1'b0);
    expect_at(5, "reset_idle", 0, 1'b0, 1'b0);
    wait_cyc(2);
    rst = 1'b0;

    // Start latency (edge 0 = cyc 11): run at edge 6, count1=1 at 11, 2 at 16.
    expect_at(16, "start_pre", 0, 1'b0, 1'b0);
    expect_at(17, "start_run", 0, 1'b1, 1'b0);
    expect_at(21, "pre_tick1", 0, 1'b1, 1'b0);
    expect_at(22, "tick1", 1, 1'b1, 1'b0);
    expect_at(26, "pre_tick2", 1, 1'b1, 1'b0);
    expect_at(27, "tick2", 2, 1'b1, 1'b0);
    // Pause at cyc 55: 38 run edges -> digits 7, prescaler 3.
    expect_at(54, "pre_pause", 7, 1'b1, 1'b0);
    expect_at(55, "pause", 7, 1'b0, 1'b0);
    expect_at(65, "pause_hold", 7, 1'b0, 1'b0);
    // Resume at cyc 77: count1 becomes 8 two edges later.
    expect_at(76, "pre_resume", 7, 1'b0, 1'b0);
    expect_at(77, "resume", 7, 1'b1, 1'b0);
    expect_at(78, "resume_p1", 7, 1'b1, 1'b0);
    expect_at(79, "resume_p2", 8, 1'b1, 1'b0);
    // Digit cascade 0009 -> 0010.
    expect_at(88, "pre_cascade", 9, 1'b1, 1'b0);
    expect_at(89, "cascade", 10, 1'b1, 1'b0);
    expect_at(6249, "mid_count", 1242, 1'b1, 1'b0);
    // Rollover 9999 -> 0000 at cyc 50039.
    expect_at(50038, "pre_wrap", 9999, 1'b1, 1'b0);
    expect_at(50039, "wrap", 0, 1'b1, 1'b1);
    expect_at(50040, "post_wrap", 0, 1'b1, 1'b0);
    expect_at(50044, "after_wrap", 1, 1'b1, 1'b0);
    // Clear press lands on the 0456 -> 0457 tick edge.
    expect_at(52323, "pre_clear", 456, 1'b1, 1'b0);
    expect_at(52324, "clear_on_tick", 0, 1'b0, 1'b0);
    expect_at(52325, "clear_p1", 0, 1'b0, 1'b0);
    expect_at(52335, "idle_hold", 0, 1'b0, 1'b0);

    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 48);
    press(1'b1, 1'b0, 70);
    press(1'b0, 1'b1, 52317);

    // Run, pause with 0005, then start+clear together from pause.
    expect_at(52346, "pre_run2", 0, 1'b0, 1'b0);
    expect_at(52347, "run2", 0, 1'b1, 1'b0);
    expect_at(52371, "pre_pause2", 4, 1'b1, 1'b0);
    expect_at(52372, "pause2", 5, 1'b0, 1'b0);
    expect_at(52396, "pre_both", 5, 1'b0, 1'b0);
    expect_at(52397, "both_clear_wins", 0, 1'b0, 1'b0);
    expect_at(52410, "both_hold", 0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 52340);
    press(1'b1, 1'b0, 52365);
    press(1'b1, 1'b1, 52390);

    // Run to 0012, one-cycle reset, then a 3-cycle start glitch.
    expect_at(52426, "pre_run3", 0, 1'b0, 1'b0);
    expect_at(52427, "run3", 0, 1'b1, 1'b0);
    expect_at(52487, "at_0012", 12, 1'b1, 1'b0);
    expect_at(52489, "pre_rst", 12, 1'b1, 1'b0);
    expect_at(52490, "reset_midrun", 0, 1'b0, 1'b0);
    expect_at(52491, "reset_midrun_p1", 0, 1'b0, 1'b0);
    expect_at(52510, "glitch", 0, 1'b0, 1'b0);
    expect_at(52530, "glitch_hold", 0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 52420);
    wait_cyc(52489);
    rst = 1'b1;
    wait_cyc(52490);
    rst = 1'b0;
    wait_cyc(52500);
    sw_if.btn_start = 1'b1;
    wait_cyc(52503);
    sw_if.btn_start = 1'b0;

    wait_cyc(52540);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expectations left, want 0", exp_q.size());
    end
    checks++;
    if (ovf_seen != 1) begin
      errors++;
      $display("FAIL overflow_pulses: got %0d, want 1", ovf_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
